// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants, FSM state encoding and index helpers for
//                the 8-point radix-2 DIT FFT engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Default sample and internal datapath widths
    localparam int DW_DEF   = 12;
    localparam int IW_DEF   = 15;

    // Twiddle ROM word width and its fixed-point scale (127 ~= 1.0)
    localparam int TWW      = 12;
    localparam int TW_SHIFT = 7;

    // Engine FSM states
    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_UNLOAD  = 2'd2;

    // 3-bit bit reversal: input order n maps to register bitrev3(n)
    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_8_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : fft_8_butterfly
//  Description : Combinational radix-2 butterfly: t = b*W (scaled, floored),
//                top = a + t, bot = a - t, all truncated to IW.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_8_butterfly
    import fft_pkg::*;
#(
    parameter int IW = IW_DEF
) (
    input  logic signed [IW-1:0]  ar,
    input  logic signed [IW-1:0]  ai,
    input  logic signed [IW-1:0]  br,
    input  logic signed [IW-1:0]  bi,
    input  logic signed [TWW-1:0] wr,
    input  logic signed [TWW-1:0] wi,
    output logic signed [IW-1:0]  top_re,
    output logic signed [IW-1:0]  top_im,
    output logic signed [IW-1:0]  bot_re,
    output logic signed [IW-1:0]  bot_im
);

    // Product width plus one bit so the sum of two products never overflows
    localparam int PW = IW + TWW + 1;

    logic signed [PW-1:0] w_br;
    logic signed [PW-1:0] w_bi;
    logic signed [PW-1:0] w_wr;
    logic signed [PW-1:0] w_wi;
    logic signed [IW-1:0] w_tr;
    logic signed [IW-1:0] w_ti;

    // Full-precision complex multiply, arithmetic right shift, then add/sub
    always_comb begin
        w_br   = PW'(br);
        w_bi   = PW'(bi);
        w_wr   = PW'(wr);
        w_wi   = PW'(wi);
        w_tr   = IW'((w_br * w_wr - w_bi * w_wi) >>> TW_SHIFT);
        w_ti   = IW'((w_br * w_wi + w_bi * w_wr) >>> TW_SHIFT);
        top_re = ar + w_tr;
        top_im = ai + w_ti;
        bot_re = ar - w_tr;
        bot_im = ai - w_ti;
    end

endmodule
`default_nettype wire

// File: rtl/spin_table_8.sv
`default_nettype none
// ============================================================================
//  Module      : spin_table_8
//  Description : 8-entry twiddle ROM, W8^k = exp(-j*2*pi*k/8) scaled by 127.
//  Revision    : 1.0 - initial release
// ============================================================================
module spin_table_8
    import fft_pkg::*;
(
    input  logic        [2:0]     idx,
    output logic signed [TWW-1:0] tw_re,
    output logic signed [TWW-1:0] tw_im
);

    // Constant lookup; 90 is round(127 * cos(pi/4))
    always_comb begin
        tw_re = '0;
        tw_im = '0;
        case (idx)
            3'd0: begin tw_re =  12'sd127; tw_im =  12'sd0;   end
            3'd1: begin tw_re =  12'sd90;  tw_im = -12'sd90;  end
            3'd2: begin tw_re =  12'sd0;   tw_im = -12'sd127; end
            3'd3: begin tw_re = -12'sd90;  tw_im = -12'sd90;  end
            3'd4: begin tw_re = -12'sd127; tw_im =  12'sd0;   end
            3'd5: begin tw_re = -12'sd90;  tw_im =  12'sd90;  end
            3'd6: begin tw_re =  12'sd0;   tw_im =  12'sd127; end
            3'd7: begin tw_re =  12'sd90;  tw_im =  12'sd90;  end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fft_8_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fft_8_engine
//  Description : Sequential 8-point radix-2 DIT FFT. Loads 8 real samples in
//                bit-reversed order, runs 12 in-place butterflies (one per
//                cycle), then streams 8 complex bins out in natural order.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_8_engine
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [IW-1:0] out_re,
    output logic signed [IW-1:0] out_im,
    output logic        [2:0]    out_idx,
    output logic                 busy
);

    logic        [1:0]     r_state;
    logic        [3:0]     r_cnt;
    logic signed [IW-1:0]  r_re [0:7];
    logic signed [IW-1:0]  r_im [0:7];

    logic        [1:0]     w_s;
    logic        [2:0]     w_b;
    logic        [2:0]     w_half;
    logic        [2:0]     w_j;
    logic        [2:0]     w_top;
    logic        [2:0]     w_bot;
    logic        [2:0]     w_tw_idx;
    logic signed [TWW-1:0] w_tw_re;
    logic signed [TWW-1:0] w_tw_im;
    logic signed [IW-1:0]  w_top_re;
    logic signed [IW-1:0]  w_top_im;
    logic signed [IW-1:0]  w_bot_re;
    logic signed [IW-1:0]  w_bot_im;

    // Decode the compute counter into stage, butterfly pair and twiddle index
    always_comb begin
        w_s      = r_cnt[3:2];
        w_b      = {1'b0, r_cnt[1:0]};
        w_half   = 3'd1 << w_s;
        w_j      = w_b & (w_half - 3'd1);
        w_top    = ((w_b >> w_s) << (w_s + 2'd1)) + w_j;
        w_bot    = w_top + w_half;
        w_tw_idx = w_j << (2'd2 - w_s);
    end

    spin_table_8 u_twiddle (
        .idx   (w_tw_idx),
        .tw_re (w_tw_re),
        .tw_im (w_tw_im)
    );

    fft_8_butterfly #(
        .IW (IW)
    ) u_butterfly (
        .ar     (r_re[w_top]),
        .ai     (r_im[w_top]),
        .br     (r_re[w_bot]),
        .bi     (r_im[w_bot]),
        .wr     (w_tw_re),
        .wi     (w_tw_im),
        .top_re (w_top_re),
        .top_im (w_top_im),
        .bot_re (w_bot_re),
        .bot_im (w_bot_im)
    );

    // FSM, counter and in-place data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_cnt   <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        r_re[bitrev3(r_cnt[2:0])] <= IW'(in_re);
                        r_im[bitrev3(r_cnt[2:0])] <= '0;
                        if (r_cnt == 4'd7) begin
                            r_state <= ST_COMPUTE;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_re[w_top] <= w_top_re;
                    r_im[w_top] <= w_top_im;
                    r_re[w_bot] <= w_bot_re;
                    r_im[w_bot] <= w_bot_im;
                    if (r_cnt == 4'd11) begin
                        r_state <= ST_UNLOAD;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (r_cnt == 4'd7) begin
                            r_state <= ST_LOAD;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Stream outputs; bins are only presented while unloading
    always_comb begin
        in_ready  = (r_state == ST_LOAD);
        busy      = (r_state != ST_LOAD);
        out_valid = (r_state == ST_UNLOAD);
        out_idx   = '0;
        out_re    = '0;
        out_im    = '0;
        if (r_state == ST_UNLOAD) begin
            out_idx = r_cnt[2:0];
            out_re  = r_re[r_cnt[2:0]];
            out_im  = r_im[r_cnt[2:0]];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_8_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_8_engine
//  Description : Self-checking bench for fft_8_engine against a behavioural
//                8-point FFT model using 127-scaled twiddles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_8_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] in_re;
    logic               out_valid;
    logic               out_ready;
    logic signed [14:0] out_re;
    logic signed [14:0] out_im;
    logic        [2:0]  out_idx;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    int c_twr [4] = '{127, 90, 0, -90};
    int c_twi [4] = '{0, -90, -127, -90};
    bit stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    fft_8_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap15(input longint v);
        logic signed [14:0] b;
        b = 15'(v);
        return b;
    endfunction

    function automatic int brev(input int n);
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    endfunction

    // Textbook iterative DIT FFT over spans m = 2, 4, 8
    function automatic void fft_model(input int x [8], output longint yr [8], output longint yi [8]);
        longint r [8];
        longint im [8];
        longint p_re, p_im, a_re, a_im;
        int t, u, w;
        for (int n = 0; n < 8; n++) begin
            r[brev(n)] = x[n];
            im[n]      = 0;
        end
        for (int m = 2; m <= 8; m = m * 2) begin
            for (int k = 0; k < 8; k = k + m) begin
                for (int j = 0; j < m / 2; j++) begin
                    t    = k + j;
                    u    = t + m / 2;
                    w    = j * (8 / m);
                    p_re = wrap15((r[u] * c_twr[w] - im[u] * c_twi[w]) >>> 7);
                    p_im = wrap15((r[u] * c_twi[w] + im[u] * c_twr[w]) >>> 7);
                    a_re = r[t];
                    a_im = im[t];
                    r[t]  = wrap15(a_re + p_re);
                    im[t] = wrap15(a_im + p_im);
                    r[u]  = wrap15(a_re - p_re);
                    im[u] = wrap15(a_im - p_im);
                end
            end
        end
        yr = r;
        yi = im;
    endfunction

    // Push 8 samples; optionally leave in_valid high with junk afterwards
    task automatic send_frame(input int x [8], input bit hold);
        int t;
        for (int i = 0; i < 8; i++) begin
            if (!hold && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_re    = 12'sh555;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_re    = 12'(x[i]);
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("in_ready_wait", longint'(in_ready), 1);
            @(negedge clk);
        end
        if (hold) begin
            in_valid = 1'b1;
            in_re    = 12'sh7FF;
        end else begin
            in_valid = 1'b0;
            in_re    = '0;
        end
    endtask

    // Full frame: load, measure latency, unload (optionally stalled), compare bins
    task automatic run_frame(input int x [8], input longint er [8], input longint ei [8],
                             input int rmode, input bit hold);
        int     lat, zeros, k, cyc, p;
        bit     rdy, have_prev;
        longint prev_re, prev_im, prev_idx;
        longint gr [8];
        longint gi [8];
        send_frame(x, hold);
        lat   = 0;
        zeros = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) zeros++;
            check("busy_compute", longint'(busy), 1);
            @(negedge clk);
            lat++;
        end
        check("first_out_latency", lat, 12);
        k = 0; cyc = 0; p = 0; have_prev = 1'b0;
        prev_re = 0; prev_im = 0; prev_idx = 0;
        while (k < 8 && cyc < 100) begin
            rdy = (rmode == 0) ? 1'b1 : stall_pat[p % 4];
            p++;
            out_ready = rdy;
            if (!in_ready) zeros++;
            if (out_valid) begin
                check("in_ready_unload", longint'(in_ready), 0);
                if (have_prev) begin
                    check("hold_idx", longint'(out_idx), prev_idx);
                    check("hold_re", out_re, prev_re);
                    check("hold_im", out_im, prev_im);
                end
                if (rdy) begin
                    check("out_idx", longint'(out_idx), k);
                    gr[k] = out_re;
                    gi[k] = out_im;
                    k++;
                    have_prev = 1'b0;
                end else begin
                    have_prev = 1'b1;
                    prev_idx  = out_idx;
                    prev_re   = out_re;
                    prev_im   = out_im;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("unload_count", k, 8);
        check("out_valid_after", longint'(out_valid), 0);
        check("in_ready_after", longint'(in_ready), 1);
        if (rmode == 0) check("in_ready_low_cycles", zeros, 20);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bin%0d_re", i), gr[i], er[i]);
            check($sformatf("bin%0d_im", i), gi[i], ei[i]);
        end
    endtask

    initial begin
        int     x [8];
        longint er [8];
        longint ei [8];

        rst = 1'b1; in_valid = 1'b0; in_re = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_out_idx", longint'(out_idx), 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        rst = 1'b0;
        @(negedge clk);

        // Impulse of 100 at n=0
        x = '{default: 0};
        x[0] = 100;
        for (int i = 0; i < 8; i++) begin er[i] = 100; ei[i] = 0; end
        run_frame(x, er, ei, 0, 1'b0);

        // All-zero frame
        x[0] = 0;
        for (int i = 0; i < 8; i++) begin er[i] = 0; ei[i] = 0; end
        run_frame(x, er, ei, 0, 1'b0);

        // Most negative impulse: checks sign extension
        x[0] = -2048;
        for (int i = 0; i < 8; i++) begin er[i] = -2048; ei[i] = 0; end
        run_frame(x, er, ei, 0, 1'b0);

        // Stalled unload with in_valid held high through compute/unload
        for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 4095)) - 2048;
        fft_model(x, er, ei);
        run_frame(x, er, ei, 1, 1'b1);

        // Reset pulse at compute cnt=5 aborts the frame
        x = '{default: 0};
        x[0] = 100;
        send_frame(x, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", longint'(in_ready), 1);
        check("abort_busy", longint'(busy), 0);
        check("abort_out_valid", longint'(out_valid), 0);
        for (int c = 0; c < 15; c++) begin
            check("abort_no_output", longint'(out_valid), 0);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin er[i] = 100; ei[i] = 0; end
        run_frame(x, er, ei, 0, 1'b0);

        // Back-to-back frames with in_valid held high
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 4095)) - 2048;
            fft_model(x, er, ei);
            run_frame(x, er, ei, 0, (f < 2));
        end

        // Random frames against the model
        for (int it = 0; it < 200; it++) begin
            for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 4095)) - 2048;
            fft_model(x, er, ei);
            run_frame(x, er, ei, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
